// File: rtl/bp_mem_cmd_throttle_if.sv
// CCE/memory command-response bundle for bp_mem_cmd_throttle.
// slave is the throttle's view; master is the CCE/memory side (the testbench).
interface bp_mem_cmd_throttle_if #(
  parameter int unsigned mem_msg_width_p   = 600,
  parameter int unsigned max_outstanding_p = 4
);
  localparam int unsigned CntWidth = $clog2(max_outstanding_p + 1);

  logic [mem_msg_width_p-1:0] cmd_i;
  logic                       cmd_v_i;
  logic                       cmd_ready_o;
  logic [mem_msg_width_p-1:0] mem_cmd_o;
  logic                       mem_cmd_v_o;
  logic                       mem_cmd_ready_i;
  logic [mem_msg_width_p-1:0] mem_resp_i;
  logic                       mem_resp_v_i;
  logic                       mem_resp_yumi_o;
  logic [mem_msg_width_p-1:0] resp_o;
  logic                       resp_v_o;
  logic                       resp_yumi_i;
  logic                       fence_i;
  logic                       fence_done_o;
  logic [CntWidth-1:0]        outstanding_o;
  logic [31:0]                stat_sent_o;
  logic [31:0]                stat_stall_o;

  modport slave (
    input  cmd_i, cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_yumi_i, fence_i,
    output cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, resp_o, resp_v_o,
           fence_done_o, outstanding_o, stat_sent_o, stat_stall_o
  );

  modport master (
    output cmd_i, cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_yumi_i, fence_i,
    input  cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, resp_o, resp_v_o,
           fence_done_o, outstanding_o, stat_sent_o, stat_stall_o
  );
endinterface

// File: rtl/bp_mem_cmd_throttle.sv
// Credit-limited memory command throttle with fence and response pass-through.
// Define BP_MEM_CMD_THROTTLE_STATS_EN to build the sent/stall statistics counters.
module bp_mem_cmd_throttle #(
  parameter int unsigned mem_msg_width_p   = 600,
  parameter int unsigned max_outstanding_p = 4,
  parameter int unsigned fifo_els_p        = 2
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  bp_mem_cmd_throttle_if.slave bus
);
  localparam int unsigned CntWidth  = $clog2(max_outstanding_p + 1);
  localparam int unsigned PtrWidth  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int unsigned FcntWidth = $clog2(fifo_els_p + 1);

  typedef logic [CntWidth-1:0]  cnt_t;
  typedef logic [PtrWidth-1:0]  ptr_t;
  typedef logic [FcntWidth-1:0] fcnt_t;
  typedef enum logic [0:0] {StRun, StFence} state_e;

  state_e                     state_q, state_d;
  logic [mem_msg_width_p-1:0] mem_q [fifo_els_p];
  ptr_t                       wr_ptr_q, rd_ptr_q;
  fcnt_t                      count_q, count_d;
  cnt_t                       outstanding_q, outstanding_d;
  logic                       ready_q;
  logic                       full, empty, cmd_ready, enq, issue, dec, fence_done;

  assign full      = (count_q == fcnt_t'(fifo_els_p));
  assign empty     = (count_q == '0);
  // ready_q holds ready low through reset and for no longer
  assign cmd_ready = ready_q & ~full;
  assign enq       = bus.cmd_v_i & cmd_ready;
  assign issue     = ~empty & bus.mem_cmd_ready_i & (state_q == StRun)
                   & (outstanding_q < cnt_t'(max_outstanding_p));
  assign dec       = bus.resp_yumi_i & (outstanding_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({enq, issue})
      2'b10:   count_d = count_q + fcnt_t'(1);
      2'b01:   count_d = count_q - fcnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({issue, dec})
      2'b10:   outstanding_d = outstanding_q + cnt_t'(1);
      2'b01:   outstanding_d = outstanding_q - cnt_t'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fence_done = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.fence_i) state_d = StFence;
      end
      StFence: begin
        if (outstanding_q == '0) begin
          fence_done = 1'b1;
          state_d    = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= StRun;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      ready_q       <= 1'b1;
      if (enq) wr_ptr_q <= (wr_ptr_q == ptr_t'(fifo_els_p - 1)) ? '0 : wr_ptr_q + ptr_t'(1);
      if (issue) rd_ptr_q <= (rd_ptr_q == ptr_t'(fifo_els_p - 1)) ? '0 : rd_ptr_q + ptr_t'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= bus.cmd_i;
  end

  assign bus.cmd_ready_o     = cmd_ready;
  assign bus.mem_cmd_v_o     = issue;
  assign bus.mem_cmd_o       = issue ? mem_q[rd_ptr_q] : '0;
  assign bus.resp_v_o        = reset_n_i & bus.mem_resp_v_i;
  assign bus.resp_o          = reset_n_i ? bus.mem_resp_i : '0;
  assign bus.mem_resp_yumi_o = reset_n_i & bus.resp_yumi_i;
  assign bus.fence_done_o    = fence_done;
  assign bus.outstanding_o   = outstanding_q;

`ifdef BP_MEM_CMD_THROTTLE_STATS_EN
  logic [31:0] sent_q, stall_q;
  logic        stall;

  assign stall = ~empty & bus.mem_cmd_ready_i & (state_q == StRun)
               & (outstanding_q == cnt_t'(max_outstanding_p));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (issue) sent_q <= sent_q + 32'd1;
      if (stall) stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stat_sent_o  = sent_q;
  assign bus.stat_stall_o = stall_q;
`else
  assign bus.stat_sent_o  = '0;
  assign bus.stat_stall_o = '0;
`endif
endmodule

// File: tb/tb_bp_mem_cmd_throttle.sv
// Self-checking bench for bp_mem_cmd_throttle: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_bp_mem_cmd_throttle;
  localparam int unsigned W    = 600;
  localparam int unsigned MAXO = 4;
  localparam int unsigned ELS  = 2;
`ifdef BP_MEM_CMD_THROTTLE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  typedef logic [W-1:0] msg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  bp_mem_cmd_throttle_if #(.mem_msg_width_p(W), .max_outstanding_p(MAXO)) bus ();

  bp_mem_cmd_throttle #(
    .mem_msg_width_p  (W),
    .max_outstanding_p(MAXO),
    .fifo_els_p       (ELS)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_i = '0; bus.cmd_v_i = 1'b0; bus.mem_cmd_ready_i = 1'b0;
    bus.mem_resp_i = '0; bus.mem_resp_v_i = 1'b0; bus.resp_yumi_i = 1'b0; bus.fence_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next();
    next();
    rst_n = 1'b1;
    next();
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    for (int i = 0; i < W; i += 32) m[i +: 32] = $urandom;
    return m;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.mem_resp_v_i = 1'b1; bus.resp_yumi_i = 1'b1; bus.mem_cmd_ready_i = 1'b1;
    bus.cmd_v_i = 1'b1;
    next();
    @(negedge clk);
    n_tests++; if (bus.cmd_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %0b want 0", bus.cmd_ready_o); end
    n_tests++; if (bus.resp_v_o !== 1'b0 || bus.mem_resp_yumi_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: got v=%0b yumi=%0b want 0 0", bus.resp_v_o,
                         bus.mem_resp_yumi_o); end
    n_tests++; if (bus.mem_cmd_v_o !== 1'b0 || bus.outstanding_o !== '0
                   || bus.fence_done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%0b outs=%0d done=%0b want 0 0 0",
                         bus.mem_cmd_v_o, bus.outstanding_o, bus.fence_done_o); end
    idle_inputs();
    next();
    rst_n = 1'b1;
    next();
    @(negedge clk);
    n_tests++; if (bus.cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %0b want 1", bus.cmd_ready_o); end
  endtask

  task automatic test_single();
    do_reset();
    bus.cmd_i = msg_t'(8'hA5); bus.cmd_v_i = 1'b1; bus.mem_cmd_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.mem_cmd_v_o !== 1'b0) begin
      n_fail++; $display("FAIL single_no_bypass: got %0b want 0", bus.mem_cmd_v_o); end
    next();
    bus.cmd_v_i = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.mem_cmd_v_o !== 1'b1 || bus.mem_cmd_o !== msg_t'(8'hA5)) begin
      n_fail++; $display("FAIL single_issue: got v=%0b d=%0h want 1 a5", bus.mem_cmd_v_o,
                         bus.mem_cmd_o); end
    next();
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_i = msg_t'(8'h5A); bus.resp_yumi_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.outstanding_o !== 3'd1) begin
      n_fail++; $display("FAIL single_outs1: got %0d want 1", bus.outstanding_o); end
    n_tests++; if (bus.resp_v_o !== 1'b1 || bus.resp_o !== msg_t'(8'h5A)
                   || bus.mem_resp_yumi_o !== 1'b1) begin
      n_fail++; $display("FAIL single_resp_pass: got v=%0b d=%0h y=%0b want 1 5a 1",
                         bus.resp_v_o, bus.resp_o, bus.mem_resp_yumi_o); end
    next();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (bus.outstanding_o !== 3'd0) begin
      n_fail++; $display("FAIL single_outs0: got %0d want 0", bus.outstanding_o); end
  endtask

  task automatic test_credit_limit();
    int k = 0;
    int issues = 0;
    do_reset();
    bus.mem_cmd_ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.cmd_v_i = (k < 6); bus.cmd_i = msg_t'(k + 1);
      bus.mem_resp_v_i = (c == 12); bus.resp_yumi_i = (c == 12);
      @(negedge clk);
      if (c < 13 && bus.mem_cmd_v_o === 1'b1) issues++;
      if (c == 12) begin
        n_tests++; if (issues != 4) begin
          n_fail++; $display("FAIL credit_cap: got %0d issues want 4", issues); end
      end
      if (c == 13) begin
        n_tests++; if (bus.mem_cmd_v_o !== 1'b1 || bus.mem_cmd_o !== msg_t'(5)) begin
          n_fail++; $display("FAIL credit_fifth: got v=%0b d=%0h want 1 5", bus.mem_cmd_v_o,
                             bus.mem_cmd_o); end
      end
      if (bus.cmd_v_i && bus.cmd_ready_o === 1'b1) k++;
      next();
    end
    idle_inputs();
    bus.mem_cmd_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.outstanding_o !== 3'd4) begin
      n_fail++; $display("FAIL credit_outs: got %0d want 4", bus.outstanding_o); end
    n_tests++; if (bus.stat_stall_o !== (StatsEn ? 32'd8 : 32'd0)) begin
      n_fail++; $display("FAIL credit_stall_stat: got %0d want %0d", bus.stat_stall_o,
                         StatsEn ? 8 : 0); end
    n_tests++; if (bus.stat_sent_o !== (StatsEn ? 32'd5 : 32'd0)) begin
      n_fail++; $display("FAIL credit_sent_stat: got %0d want %0d", bus.stat_sent_o,
                         StatsEn ? 5 : 0); end
    next();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      bus.mem_cmd_ready_i = (c >= 3);
      bus.cmd_v_i = (c <= 4); bus.cmd_i = msg_t'(12'h100 + ((c > 2) ? 2 : c));
      @(negedge clk);
      if (c == 2) begin
        n_tests++; if (bus.cmd_ready_o !== 1'b0 || bus.mem_cmd_v_o !== 1'b0) begin
          n_fail++; $display("FAIL bp_full: got rdy=%0b v=%0b want 0 0", bus.cmd_ready_o,
                             bus.mem_cmd_v_o); end
      end
      if (c >= 3 && c <= 5) begin
        n_tests++; if (bus.mem_cmd_v_o !== 1'b1 || bus.mem_cmd_o !== msg_t'(12'h100 + c - 3))
        begin
          n_fail++; $display("FAIL bp_order%0d: got v=%0b d=%0h want 1 %0h", c,
                             bus.mem_cmd_v_o, bus.mem_cmd_o, 12'h100 + c - 3); end
      end
      if (c == 4) begin
        n_tests++; if (bus.cmd_ready_o !== 1'b1) begin
          n_fail++; $display("FAIL bp_ready_back: got %0b want 1", bus.cmd_ready_o); end
      end
      if (c == 6) begin
        n_tests++; if (bus.mem_cmd_v_o !== 1'b0) begin
          n_fail++; $display("FAIL bp_drained: got %0b want 0", bus.mem_cmd_v_o); end
      end
      next();
    end
  endtask

  task automatic test_simul_fence();
    do_reset();
    bus.mem_cmd_ready_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.cmd_v_i = (c <= 2 || c == 4); bus.cmd_i = msg_t'(16'hC000 + c);
      bus.fence_i = (c == 3);
      bus.mem_resp_v_i = (c == 3 || c == 5 || c == 6); bus.resp_yumi_i = bus.mem_resp_v_i;
      @(negedge clk);
      if (c == 3) begin
        n_tests++; if (bus.mem_cmd_v_o !== 1'b1 || bus.mem_cmd_o !== msg_t'(16'hC002)
                       || bus.outstanding_o !== 3'd2) begin
          n_fail++; $display("FAIL sf_issue: got v=%0b d=%0h outs=%0d want 1 c002 2",
                             bus.mem_cmd_v_o, bus.mem_cmd_o, bus.outstanding_o); end
      end
      if (c == 4) begin
        n_tests++; if (bus.outstanding_o !== 3'd2 || bus.fence_done_o !== 1'b0) begin
          n_fail++; $display("FAIL sf_hold: got outs=%0d done=%0b want 2 0",
                             bus.outstanding_o, bus.fence_done_o); end
      end
      if (c == 5 || c == 6) begin
        n_tests++; if (bus.mem_cmd_v_o !== 1'b0 || bus.fence_done_o !== 1'b0) begin
          n_fail++; $display("FAIL sf_blocked%0d: got v=%0b done=%0b want 0 0", c,
                             bus.mem_cmd_v_o, bus.fence_done_o); end
      end
      if (c == 7) begin
        n_tests++; if (bus.outstanding_o !== 3'd0 || bus.fence_done_o !== 1'b1
                       || bus.mem_cmd_v_o !== 1'b0) begin
          n_fail++; $display("FAIL sf_done: got outs=%0d done=%0b v=%0b want 0 1 0",
                             bus.outstanding_o, bus.fence_done_o, bus.mem_cmd_v_o); end
      end
      if (c == 8) begin
        n_tests++; if (bus.fence_done_o !== 1'b0 || bus.mem_cmd_v_o !== 1'b1
                       || bus.mem_cmd_o !== msg_t'(16'hC004)) begin
          n_fail++; $display("FAIL sf_resume: got done=%0b v=%0b d=%0h want 0 1 c004",
                             bus.fence_done_o, bus.mem_cmd_v_o, bus.mem_cmd_o); end
      end
      next();
    end
  endtask

  task automatic test_fence_idle();
    do_reset();
    bus.mem_cmd_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.fence_i = (c == 0); bus.cmd_v_i = (c == 0); bus.cmd_i = msg_t'(16'hE0E0);
      @(negedge clk);
      if (c == 0) begin
        n_tests++; if (bus.fence_done_o !== 1'b0) begin
          n_fail++; $display("FAIL fi_early: got %0b want 0", bus.fence_done_o); end
      end
      if (c == 1) begin
        n_tests++; if (bus.fence_done_o !== 1'b1 || bus.mem_cmd_v_o !== 1'b0) begin
          n_fail++; $display("FAIL fi_done: got done=%0b v=%0b want 1 0", bus.fence_done_o,
                             bus.mem_cmd_v_o); end
      end
      if (c == 2) begin
        n_tests++; if (bus.fence_done_o !== 1'b0 || bus.mem_cmd_v_o !== 1'b1
                       || bus.mem_cmd_o !== msg_t'(16'hE0E0)) begin
          n_fail++; $display("FAIL fi_run: got done=%0b v=%0b d=%0h want 0 1 e0e0",
                             bus.fence_done_o, bus.mem_cmd_v_o, bus.mem_cmd_o); end
      end
      next();
    end
  endtask

  task automatic test_reset_mid_fence();
    do_reset();
    bus.mem_cmd_ready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.cmd_v_i = (c <= 2 || c == 5); bus.cmd_i = msg_t'(c + 1);
      bus.fence_i = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        n_tests++; if (bus.outstanding_o !== 3'd3) begin
          n_fail++; $display("FAIL rmf_outs3: got %0d want 3", bus.outstanding_o); end
      end
      if (c < 6) next();
    end
    n_tests++; if (bus.mem_cmd_v_o !== 1'b0 || bus.fence_done_o !== 1'b0) begin
      n_fail++; $display("FAIL rmf_fenced: got v=%0b done=%0b want 0 0", bus.mem_cmd_v_o,
                         bus.fence_done_o); end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.outstanding_o !== '0 || bus.mem_cmd_v_o !== 1'b0
                   || bus.fence_done_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rmf_async: got outs=%0d v=%0b done=%0b rdy=%0b want 0 0 0 0",
                         bus.outstanding_o, bus.mem_cmd_v_o, bus.fence_done_o,
                         bus.cmd_ready_o); end
    idle_inputs();
    bus.mem_cmd_ready_i = 1'b1;
    next();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next();
      @(negedge clk);
      n_tests++; if (bus.cmd_ready_o !== 1'b1 || bus.fence_done_o !== 1'b0
                     || bus.mem_cmd_v_o !== 1'b0 || bus.outstanding_o !== '0) begin
        n_fail++; $display("FAIL rmf_after%0d: got rdy=%0b done=%0b v=%0b outs=%0d want 1 0 0 0",
                           c, bus.cmd_ready_o, bus.fence_done_o, bus.mem_cmd_v_o,
                           bus.outstanding_o); end
      n_tests++; if (bus.stat_sent_o !== '0 || bus.stat_stall_o !== '0) begin
        n_fail++; $display("FAIL rmf_stats%0d: got %0d %0d want 0 0", c, bus.stat_sent_o,
                           bus.stat_stall_o); end
    end
  endtask

  task automatic test_random();
    msg_t q_m[$];
    int   outs_m = 0;
    bit   fence_m = 1'b0;
    int   sent_m = 0;
    int   stall_m = 0;
    bit   exp_ready, exp_issue, exp_done, yumi;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.cmd_v_i = ($urandom_range(0, 1) == 1); bus.cmd_i = rand_msg();
      bus.mem_cmd_ready_i = ($urandom_range(0, 3) != 0);
      bus.mem_resp_v_i = ($urandom_range(0, 1) == 1); bus.mem_resp_i = rand_msg();
      yumi = bus.mem_resp_v_i && outs_m > 0 && ($urandom_range(0, 2) != 0);
      bus.resp_yumi_i = yumi;
      bus.fence_i = ($urandom_range(0, 19) == 0);
      exp_ready = (q_m.size() < ELS);
      exp_issue = q_m.size() > 0 && bus.mem_cmd_ready_i && outs_m < MAXO && !fence_m;
      exp_done  = fence_m && outs_m == 0;
      @(negedge clk);
      n_tests++; if (bus.cmd_ready_o !== exp_ready || bus.mem_cmd_v_o !== exp_issue
                     || bus.fence_done_o !== exp_done) begin
        n_fail++; $display("FAIL rnd_ctl%0d: got rdy=%0b v=%0b done=%0b want %0b %0b %0b", c,
                           bus.cmd_ready_o, bus.mem_cmd_v_o, bus.fence_done_o, exp_ready,
                           exp_issue, exp_done); end
      if (exp_issue) begin
        n_tests++; if (bus.mem_cmd_o !== q_m[0]) begin
          n_fail++; $display("FAIL rnd_data%0d: got %0h want %0h", c, bus.mem_cmd_o, q_m[0]);
        end
      end
      n_tests++; if (bus.outstanding_o !== 3'(outs_m)) begin
        n_fail++; $display("FAIL rnd_outs%0d: got %0d want %0d", c, bus.outstanding_o, outs_m);
      end
      n_tests++; if (bus.resp_v_o !== bus.mem_resp_v_i || bus.resp_o !== bus.mem_resp_i
                     || bus.mem_resp_yumi_o !== yumi) begin
        n_fail++; $display("FAIL rnd_resp%0d: got v=%0b y=%0b want %0b %0b", c, bus.resp_v_o,
                           bus.mem_resp_yumi_o, bus.mem_resp_v_i, yumi); end
      n_tests++; if (bus.stat_sent_o !== (StatsEn ? 32'(sent_m) : 32'd0)
                     || bus.stat_stall_o !== (StatsEn ? 32'(stall_m) : 32'd0)) begin
        n_fail++; $display("FAIL rnd_stats%0d: got %0d %0d want %0d %0d", c, bus.stat_sent_o,
                           bus.stat_stall_o, StatsEn ? sent_m : 0, StatsEn ? stall_m : 0); end
      if (q_m.size() > 0 && bus.mem_cmd_ready_i && !fence_m && outs_m == MAXO) stall_m++;
      if (exp_issue) begin
        void'(q_m.pop_front());
        sent_m++;
      end
      if (bus.cmd_v_i && exp_ready) q_m.push_back(bus.cmd_i);
      outs_m = outs_m + (exp_issue ? 1 : 0) - (yumi ? 1 : 0);
      if (!fence_m && bus.fence_i) fence_m = 1'b1;
      else if (exp_done) fence_m = 1'b0;
      next();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_credit_limit();
    test_backpressure();
    test_simul_fence();
    test_fence_idle();
    test_reset_mid_fence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
